player_ctrl: RTL and testbench

//  Parametrised front-panel controller for the MP3 player: volume attenuation and track selection.

---
 rtl/player_ctrl_pkg.sv | 22 ++
 rtl/player_ctrl_btn_sample.sv | 63 ++++++
 rtl/player_ctrl.sv | 118 +++++++++++
 tb/tb_player_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/player_ctrl_pkg.sv
// Shared widths, types and helpers for the player front-panel controller.
// Widths are sized for the largest legal configuration (16 volume steps, 32 tracks).
package player_pkg;

  localparam int MAX_VOL_STEPS = 16;
  localparam int MAX_TRACKS    = 32;

  localparam int VOL_W = $clog2(MAX_VOL_STEPS);
  localparam int TRK_W = $clog2(MAX_TRACKS);

  localparam int BTN_NEXT = 0;
  localparam int BTN_PRE  = 1;
  localparam int BTN_DEC  = 2;
  localparam int BTN_INC  = 3;

  typedef logic [VOL_W-1:0] att_t;

  function automatic logic [MAX_TRACKS-1:0] onehot(input logic [TRK_W-1:0] idx);
    onehot = MAX_TRACKS'(1) << idx;
  endfunction

endpackage

// File: rtl/player_ctrl_btn_sample.sv
// One push-button: 2-FF synchroniser, tick-rate sampling and press-edge detection.
// With PLAYER_CTRL_AUTOREPEAT_EN defined and REPEAT_EN set, a hold counter adds auto-repeat.
module player_ctrl_btn_sample #(
  parameter int REPEAT_TICKS = 3,
  parameter bit REPEAT_EN    = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  input  logic i_tick,
  output logic o_act
);

  logic [1:0] r_sync;
  logic       r_prev;
  logic       w_s;
  logic       w_press;

  if (REPEAT_EN && REPEAT_TICKS < 1) begin : g_chk
    $error("player_ctrl_btn_sample: REPEAT_TICKS must be >= 1");
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      if (i_tick) r_prev <= r_sync[1];
    end
  end

  // The current sample is the synchroniser output during the tick cycle itself.
  assign w_s     = r_sync[1];
  assign w_press = i_tick & w_s & ~r_prev;

`ifdef PLAYER_CTRL_AUTOREPEAT_EN
  if (REPEAT_EN) begin : g_rep
    localparam int HW = $clog2(REPEAT_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(REPEAT_TICKS);
    localparam logic [HW-1:0] HOLD_RPT = HW'(REPEAT_TICKS - 1);

    logic [HW-1:0] r_hold;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_hold <= '0;
      end else if (i_tick) begin
        if (!w_s) r_hold <= '0;
        else if (r_hold != HOLD_MAX) r_hold <= r_hold + 1'b1;
      end
    end

    // r_hold counts earlier held ticks, so this tick is held tick number r_hold+1.
    assign o_act = w_press | (i_tick & w_s & (r_hold >= HOLD_RPT));
  end else begin : g_norep
    assign o_act = w_press;
  end
`else
  assign o_act = w_press;
`endif

endmodule

// File: rtl/player_ctrl.sv
// Front-panel controller: debounced volume attenuation and track selection for the MP3 player.
// Define PLAYER_CTRL_AUTOREPEAT_EN to enable auto-repeat on held volume buttons.
module player_ctrl
  import player_pkg::*;
#(
  parameter int         TICK_DIV      = 10_000_000,
  parameter int         VOL_STEPS     = 16,
  parameter logic [7:0] VOL_STEP_SIZE = 8'h10,
  parameter int         VOL_INIT      = 6,
  parameter int         NUM_TRACKS    = 5,
  parameter int         REPEAT_TICKS  = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_inc_vol,
  input  logic                          i_dec_vol,
  input  logic                          i_pre_music,
  input  logic                          i_next_music,
  output logic [7:0]                    o_vol,
  output logic [$clog2(VOL_STEPS)-1:0]  o_vol_level,
  output logic [$clog2(NUM_TRACKS)-1:0] o_track_idx,
  output logic [NUM_TRACKS-1:0]         o_music_select,
  output logic                          o_is_changed_n
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int LW = $clog2(VOL_STEPS);
  localparam int TW = $clog2(NUM_TRACKS);

  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam att_t          ATT_MAX  = att_t'(VOL_STEPS - 1);
  localparam att_t          ATT_INIT = att_t'(VOL_INIT);
  localparam logic [TW-1:0] TRK_LAST = TW'(NUM_TRACKS - 1);

  if (TICK_DIV < 2 || VOL_STEPS < 2 || VOL_STEPS > MAX_VOL_STEPS ||
      NUM_TRACKS < 2 || NUM_TRACKS > MAX_TRACKS ||
      VOL_INIT < 0 || VOL_INIT >= VOL_STEPS ||
      (VOL_STEPS - 1) * int'(VOL_STEP_SIZE) > 255) begin : g_chk
    $error("player_ctrl: parameter out of range");
  end

  logic [CW-1:0] r_tick_cnt;
  logic          w_tick;
  logic [3:0]    w_btn;
  logic [3:0]    w_act;
  att_t          r_att;
  att_t          w_att_nxt;
  logic [TW-1:0] r_trk;
  logic [TW-1:0] w_trk_nxt;
  logic          w_trk_chg;
  logic          r_chg_n;

  assign w_tick = (r_tick_cnt == CNT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  assign w_btn[BTN_INC]  = i_inc_vol;
  assign w_btn[BTN_DEC]  = i_dec_vol;
  assign w_btn[BTN_PRE]  = i_pre_music;
  assign w_btn[BTN_NEXT] = i_next_music;

  // Only the volume buttons may auto-repeat.
  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    player_ctrl_btn_sample #(
      .REPEAT_TICKS (REPEAT_TICKS),
      .REPEAT_EN    (gi == BTN_INC || gi == BTN_DEC)
    ) u_btn (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_btn  (w_btn[gi]),
      .i_tick (w_tick),
      .o_act  (w_act[gi])
    );
  end

  always_comb begin
    w_att_nxt = r_att;
    if (w_act[BTN_INC] && !w_act[BTN_DEC] && r_att != '0)
      w_att_nxt = r_att - 1'b1;
    else if (w_act[BTN_DEC] && !w_act[BTN_INC] && r_att != ATT_MAX)
      w_att_nxt = r_att + 1'b1;
  end

  always_comb begin
    w_trk_nxt = r_trk;
    w_trk_chg = 1'b0;
    if (w_act[BTN_NEXT] && !w_act[BTN_PRE]) begin
      w_trk_nxt = (r_trk == TRK_LAST) ? '0 : r_trk + 1'b1;
      w_trk_chg = 1'b1;
    end else if (w_act[BTN_PRE] && !w_act[BTN_NEXT]) begin
      w_trk_nxt = (r_trk == '0) ? TRK_LAST : r_trk - 1'b1;
      w_trk_chg = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_att   <= ATT_INIT;
      r_trk   <= '0;
      r_chg_n <= 1'b1;
    end else begin
      r_att   <= w_att_nxt;
      r_trk   <= w_trk_nxt;
      r_chg_n <= ~w_trk_chg;
    end
  end

  assign o_vol          = 8'(r_att) * VOL_STEP_SIZE;
  assign o_vol_level    = LW'(ATT_MAX - r_att);
  assign o_track_idx    = r_trk;
  assign o_music_select = NUM_TRACKS'(onehot(TRK_W'(r_trk)));
  assign o_is_changed_n = r_chg_n;

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl with a tick-level reference model and a directed vector table.
module tb_player_ctrl;

  localparam int TICK_DIV     = 4;
  localparam int VOL_STEPS    = 16;
  localparam int VOL_INIT     = 6;
  localparam int NUM_TRACKS   = 5;
  localparam int REPEAT_TICKS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inc = 1'b0, dec = 1'b0, pre = 1'b0, nxt = 1'b0;
  logic [7:0] vol;
  logic [3:0] lvl;
  logic [2:0] idx;
  logic [4:0] ms;
  logic       chg_n;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, one update per sample tick.
  int         m_att, m_idx, m_hold_inc, m_hold_dec;
  logic [3:0] m_prev;
  bit         m_chg;

  typedef struct {
    logic [3:0] btn;   // {inc, dec, pre, next}
    logic [7:0] vol;
    logic [3:0] lvl;
    logic [2:0] idx;
    logic       chg_n;
  } vec_t;

  vec_t tbl[13];

  always #5 clk = ~clk;

  player_ctrl #(
    .TICK_DIV      (TICK_DIV),
    .VOL_STEPS     (VOL_STEPS),
    .VOL_STEP_SIZE (8'h10),
    .VOL_INIT      (VOL_INIT),
    .NUM_TRACKS    (NUM_TRACKS),
    .REPEAT_TICKS  (REPEAT_TICKS)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_inc_vol      (inc),
    .i_dec_vol      (dec),
    .i_pre_music    (pre),
    .i_next_music   (nxt),
    .o_vol          (vol),
    .o_vol_level    (lvl),
    .o_track_idx    (idx),
    .o_music_select (ms),
    .o_is_changed_n (chg_n)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_att = VOL_INIT; m_idx = 0; m_prev = '0;
    m_hold_inc = 0; m_hold_dec = 0; m_chg = 0;
  endtask

  task automatic model_step(input logic [3:0] b);
    logic [3:0] press;
    bit a_inc, a_dec;
    press = b & ~m_prev;
    a_inc = press[3];
    a_dec = press[2];
`ifdef PLAYER_CTRL_AUTOREPEAT_EN
    m_hold_inc = b[3] ? m_hold_inc + 1 : 0;
    m_hold_dec = b[2] ? m_hold_dec + 1 : 0;
    if (m_hold_inc >= REPEAT_TICKS) a_inc = 1;
    if (m_hold_dec >= REPEAT_TICKS) a_dec = 1;
`endif
    if (a_inc && !a_dec && m_att > 0) m_att--;
    else if (a_dec && !a_inc && m_att < VOL_STEPS - 1) m_att++;
    m_chg = 0;
    if (press[0] && !press[1]) begin m_idx = (m_idx + 1) % NUM_TRACKS; m_chg = 1; end
    else if (press[1] && !press[0]) begin m_idx = (m_idx + NUM_TRACKS - 1) % NUM_TRACKS; m_chg = 1; end
    m_prev = b;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".vol"}, vol, m_att * 16);
    chk({tag, ".lvl"}, lvl, VOL_STEPS - 1 - m_att);
    chk({tag, ".idx"}, idx, m_idx);
    chk({tag, ".ms"}, ms, 1 << m_idx);
    chk({tag, ".chg_n"}, chg_n, m_chg ? 0 : 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".vol"}, vol, 8'h60);
    chk({tag, ".lvl"}, lvl, 9);
    chk({tag, ".idx"}, idx, 0);
    chk({tag, ".ms"}, ms, 5'b00001);
    chk({tag, ".chg_n"}, chg_n, 1);
  endtask

  // Called #1 after a tick-ending edge (or reset release); returns #1 after the next one.
  task automatic run_tick(input logic [3:0] b);
    {inc, dec, pre, nxt} = b;
    @(posedge clk); #1;
    chk("chg_n_released", chg_n, 1);
    repeat (TICK_DIV - 1) @(posedge clk);
    #1;
    model_step(b);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    {inc, dec, pre, nxt} = 4'b0000;
    #1;
    check_reset_vals("rst_async");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    tbl[0]  = '{4'b0001, 8'h60, 4'd9,  3'd1, 1'b0};
    tbl[1]  = '{4'b0000, 8'h60, 4'd9,  3'd1, 1'b1};
    tbl[2]  = '{4'b1000, 8'h50, 4'd10, 3'd1, 1'b1};
    tbl[3]  = '{4'b0000, 8'h50, 4'd10, 3'd1, 1'b1};
    tbl[4]  = '{4'b0011, 8'h50, 4'd10, 3'd1, 1'b1};
    tbl[5]  = '{4'b0000, 8'h50, 4'd10, 3'd1, 1'b1};
    tbl[6]  = '{4'b0010, 8'h50, 4'd10, 3'd0, 1'b0};
    tbl[7]  = '{4'b0000, 8'h50, 4'd10, 3'd0, 1'b1};
    tbl[8]  = '{4'b0010, 8'h50, 4'd10, 3'd4, 1'b0};
    tbl[9]  = '{4'b1100, 8'h50, 4'd10, 3'd4, 1'b1};
    tbl[10] = '{4'b0100, 8'h50, 4'd10, 3'd4, 1'b1};
    tbl[11] = '{4'b0000, 8'h50, 4'd10, 3'd4, 1'b1};
    tbl[12] = '{4'b0100, 8'h60, 4'd9,  3'd4, 1'b1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    rst = 1'b0;
    model_reset();

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      run_tick(tbl[i].btn);
      chk($sformatf("tbl%0d.vol", i), vol, tbl[i].vol);
      chk($sformatf("tbl%0d.lvl", i), lvl, tbl[i].lvl);
      chk($sformatf("tbl%0d.idx", i), idx, tbl[i].idx);
      chk($sformatf("tbl%0d.ms", i), ms, 1 << tbl[i].idx);
      chk($sformatf("tbl%0d.chg_n", i), chg_n, tbl[i].chg_n);
    end

    // Volume saturation at both ends.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      run_tick(4'b1000); check_model("inc_sat");
      run_tick(4'b0000); check_model("inc_sat_rel");
    end
    chk("sat_loud.vol", vol, 8'h00);
    chk("sat_loud.lvl", lvl, 15);
    for (int i = 0; i < 16; i++) begin
      run_tick(4'b0100); check_model("dec_sat");
      run_tick(4'b0000); check_model("dec_sat_rel");
    end
    chk("sat_quiet.vol", vol, 8'hF0);
    chk("sat_quiet.lvl", lvl, 0);

    // Track wrap in both directions.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_tick(4'b0001);
      chk("next_wrap.idx", idx, (i + 1) % 5);
      chk("next_wrap.chg_n", chg_n, 0);
      run_tick(4'b0000);
      check_model("next_wrap_rel");
    end
    run_tick(4'b0010);
    chk("pre_wrap.idx", idx, 4);
    chk("pre_wrap.ms", ms, 5'b10000);
    run_tick(4'b0000);

    // Simultaneous opposing buttons.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_tick(4'b0011); check_model("both_trk");
    end
    run_tick(4'b0000);
    run_tick(4'b1100); check_model("both_vol");
    chk("both_vol.vol", vol, 8'h60);
    run_tick(4'b0000);

    // Long hold on dec_vol.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_tick(4'b0100); check_model("hold_dec");
    end
`ifdef PLAYER_CTRL_AUTOREPEAT_EN
    chk("hold_dec.final_vol", vol, 8'hD0);
`else
    chk("hold_dec.final_vol", vol, 8'h70);
`endif
    run_tick(4'b0000);

    // Reset asserted mid-hold and mid-tick after a track change.
    do_reset();
    run_tick(4'b0001);
    run_tick(4'b0000);
    dec = 1'b1;
    repeat (TICK_DIV + 2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    dec = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3 * TICK_DIV; i++) begin
      @(posedge clk); #1;
      chk("post_rst.chg_n", chg_n, 1);
    end
    check_reset_vals("post_rst");

    // Randomized ticks against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic [3:0] b;
      b = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) b = m_prev;
      run_tick(b);
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
